// File: rtl/spsram_arb2.sv
// spsram_arb2: two-port round-robin arbiter/sequencer
// for a single-port SRAM with 1-cycle synchronous read.
module spsram_arb2 #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_req_valid0,
  input  logic               i_req_valid1,
  output logic               o_req_ready0,
  output logic               o_req_ready1,
  input  logic               i_req_we0,
  input  logic               i_req_we1,
  input  logic [BW_ADDR-1:0] i_req_addr0,
  input  logic [BW_ADDR-1:0] i_req_addr1,
  input  logic [BW_DATA-1:0] i_req_data0,
  input  logic [BW_DATA-1:0] i_req_data1,
  output logic               o_rsp_valid0,
  output logic               o_rsp_valid1,
  output logic [BW_DATA-1:0] o_rsp_data0,
  output logic [BW_DATA-1:0] o_rsp_data1,
  output logic               o_mem_cen,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic [BW_DATA-1:0] o_mem_data,
  input  logic [BW_DATA-1:0] i_mem_data
);

  logic               prio;
  logic               acc0;
  logic               acc1;
  logic               acc;
  logic               sel_we;
  logic [BW_ADDR-1:0] sel_addr;
  logic [BW_DATA-1:0] sel_data;
  logic               t1_v;
  logic               t1_id;
  logic               t2_v;
  logic               t2_id;

  // Grant: sole requester wins; on contention prio decides.
  assign acc0 = i_req_valid0 & (~i_req_valid1 | ~prio);
  assign acc1 = i_req_valid1 & (~i_req_valid0 | prio);
  assign acc  = acc0 | acc1;

  assign o_req_ready0 = acc0;
  assign o_req_ready1 = acc1;

  // Mux the fields of the granted port.
  always_comb begin
    sel_we   = i_req_we0;
    sel_addr = i_req_addr0;
    sel_data = i_req_data0;
    unique case (1'b1)
      acc1: begin
        sel_we   = i_req_we1;
        sel_addr = i_req_addr1;
        sel_data = i_req_data1;
      end
      default: ;
    endcase
  end

  // Round-robin pointer: points away from the last winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio <= 1'b0;
    end else if (acc) begin
      prio <= acc0;
    end
  end

  // Stage 1: registered SRAM command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_mem_cen  <= 1'b0;
      o_mem_wen  <= 1'b0;
      o_mem_oen  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      o_mem_cen <= acc;
      o_mem_wen <= acc & sel_we;
      o_mem_oen <= acc & ~sel_we;
      if (acc) begin
        o_mem_addr <= sel_addr;
        o_mem_data <= sel_data;
      end
    end
  end

  // Read tag follows the command and the SRAM output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t1_v  <= 1'b0;
      t1_id <= 1'b0;
      t2_v  <= 1'b0;
      t2_id <= 1'b0;
    end else begin
      t1_v  <= acc & ~sel_we;
      t1_id <= acc1;
      t2_v  <= t1_v;
      t2_id <= t1_id;
    end
  end

  // Stage 2: capture read data for the tagged port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rsp_valid0 <= 1'b0;
      o_rsp_valid1 <= 1'b0;
      o_rsp_data0  <= '0;
      o_rsp_data1  <= '0;
    end else begin
      o_rsp_valid0 <= t2_v & ~t2_id;
      o_rsp_valid1 <= t2_v & t2_id;
      if (t2_v & ~t2_id) o_rsp_data0 <= i_mem_data;
      if (t2_v & t2_id)  o_rsp_data1 <= i_mem_data;
    end
  end

endmodule
